// File: rtl/arm_id_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : arm_id_decode_stage                                               |
// | Brief  : ARM decode plus condition check, registered into ID/EXE stage.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module arm_id_decode_stage #(
    parameter int PC_W    = 32,
    parameter int CNT_W   = 16,
    parameter bit EN_LINK = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      instr,
    input  logic [PC_W-1:0]  pc_in,
    input  logic [3:0]       nzcv,
    input  logic             stall,
    input  logic             flush,
    input  logic             hazard,
    output logic             out_valid,
    output logic             wb_en,
    output logic             mem_r_en,
    output logic             mem_w_en,
    output logic             b,
    output logic             s,
    output logic             imm,
    output logic             link,
    output logic             illegal,
    output logic [3:0]       exe_cmd,
    output logic [3:0]       rn,
    output logic [3:0]       rd,
    output logic [11:0]      shift_operand,
    output logic [23:0]      simm24,
    output logic [PC_W-1:0]  pc_out,
    output logic [CNT_W-1:0] issued_cnt
);

    localparam logic [3:0] c_CMD_NONE = 4'b0000;
    localparam logic [3:0] c_CMD_MOV  = 4'b0001;
    localparam logic [3:0] c_CMD_ADD  = 4'b0010;
    localparam logic [3:0] c_CMD_ADC  = 4'b0011;
    localparam logic [3:0] c_CMD_SUB  = 4'b0100;
    localparam logic [3:0] c_CMD_SBC  = 4'b0101;
    localparam logic [3:0] c_CMD_AND  = 4'b0110;
    localparam logic [3:0] c_CMD_ORR  = 4'b0111;
    localparam logic [3:0] c_CMD_EOR  = 4'b1000;
    localparam logic [3:0] c_CMD_MVN  = 4'b1001;
    localparam logic [3:0] c_REG_LR   = 4'd14;

    logic [1:0] w_mode;
    logic [3:0] w_opcode;
    logic       w_n, w_z, w_c, w_v;
    logic       w_cond_pass;
    logic       w_wb_en, w_mem_r, w_mem_w, w_b, w_s, w_imm, w_link, w_illegal;
    logic [3:0] w_exe_cmd;
    logic       w_link_fin;
    logic       w_clear;
    logic       w_issue;

    assign w_mode   = instr[27:26];
    assign w_opcode = instr[24:21];
    assign {w_n, w_z, w_c, w_v} = nzcv;

    always_comb begin
        w_cond_pass = 1'b0;
        case (instr[31:28])
            4'b0000: w_cond_pass = w_z;
            4'b0001: w_cond_pass = ~w_z;
            4'b0010: w_cond_pass = w_c;
            4'b0011: w_cond_pass = ~w_c;
            4'b0100: w_cond_pass = w_n;
            4'b0101: w_cond_pass = ~w_n;
            4'b0110: w_cond_pass = w_v;
            4'b0111: w_cond_pass = ~w_v;
            4'b1000: w_cond_pass = w_c & ~w_z;
            4'b1001: w_cond_pass = ~w_c | w_z;
            4'b1010: w_cond_pass = (w_n == w_v);
            4'b1011: w_cond_pass = (w_n != w_v);
            4'b1100: w_cond_pass = ~w_z & (w_n == w_v);
            4'b1101: w_cond_pass = w_z | (w_n != w_v);
            4'b1110: w_cond_pass = 1'b1;
            default: w_cond_pass = 1'b0;
        endcase
    end

    always_comb begin
        w_wb_en   = 1'b0;
        w_mem_r   = 1'b0;
        w_mem_w   = 1'b0;
        w_b       = 1'b0;
        w_s       = 1'b0;
        w_imm     = 1'b0;
        w_link    = 1'b0;
        w_illegal = 1'b0;
        w_exe_cmd = c_CMD_NONE;
        case (w_mode)
            2'b00: begin
                w_wb_en = 1'b1;
                w_s     = instr[20];
                w_imm   = instr[25];
                case (w_opcode)
                    4'b1101: w_exe_cmd = c_CMD_MOV;
                    4'b1111: w_exe_cmd = c_CMD_MVN;
                    4'b0100: w_exe_cmd = c_CMD_ADD;
                    4'b0101: w_exe_cmd = c_CMD_ADC;
                    4'b0010: w_exe_cmd = c_CMD_SUB;
                    4'b0110: w_exe_cmd = c_CMD_SBC;
                    4'b0000: w_exe_cmd = c_CMD_AND;
                    4'b1100: w_exe_cmd = c_CMD_ORR;
                    4'b0001: w_exe_cmd = c_CMD_EOR;
                    // Compare/test only set flags, never write a register
                    4'b1010: begin w_exe_cmd = c_CMD_SUB; w_s = 1'b1; w_wb_en = 1'b0; end
                    4'b1000: begin w_exe_cmd = c_CMD_AND; w_s = 1'b1; w_wb_en = 1'b0; end
                    default: begin
                        w_illegal = 1'b1;
                        w_wb_en   = 1'b0;
                        w_s       = 1'b0;
                        w_imm     = 1'b0;
                    end
                endcase
            end
            2'b01: begin
                if (w_opcode == 4'b0100) begin
                    w_exe_cmd = c_CMD_ADD;
                    w_mem_r   = instr[20];
                    w_mem_w   = ~instr[20];
                    w_wb_en   = instr[20];
                end else begin
                    w_illegal = 1'b1;
                end
            end
            2'b10: begin
                w_b     = 1'b1;
                w_link  = EN_LINK & instr[24];
                w_wb_en = EN_LINK & instr[24];
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // LR redirect follows the link bit after the condition gate
    assign w_link_fin = w_link & w_cond_pass;
    assign w_clear    = flush | (~stall & (hazard | ~in_valid));
    assign w_issue    = ~flush & ~stall & ~hazard & in_valid & w_cond_pass;

    logic             r_out_valid, r_wb_en, r_mem_r_en, r_mem_w_en, r_b, r_s, r_imm, r_link, r_illegal;
    logic [3:0]       r_exe_cmd, r_rn, r_rd;
    logic [11:0]      r_shift_operand;
    logic [23:0]      r_simm24;
    logic [PC_W-1:0]  r_pc_out;
    logic [CNT_W-1:0] r_issued_cnt;

    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_out_valid     <= 1'b0;
            r_wb_en         <= 1'b0;
            r_mem_r_en      <= 1'b0;
            r_mem_w_en      <= 1'b0;
            r_b             <= 1'b0;
            r_s             <= 1'b0;
            r_imm           <= 1'b0;
            r_link          <= 1'b0;
            r_illegal       <= 1'b0;
            r_exe_cmd       <= 4'd0;
            r_rn            <= 4'd0;
            r_rd            <= 4'd0;
            r_shift_operand <= 12'd0;
            r_simm24        <= 24'd0;
            r_pc_out        <= '0;
        end else if (!stall) begin
            r_out_valid     <= w_cond_pass;
            r_wb_en         <= w_wb_en & w_cond_pass;
            r_mem_r_en      <= w_mem_r & w_cond_pass;
            r_mem_w_en      <= w_mem_w & w_cond_pass;
            r_b             <= w_b & w_cond_pass;
            r_s             <= w_s & w_cond_pass;
            r_imm           <= w_imm;
            r_link          <= w_link_fin;
            r_illegal       <= w_illegal & w_cond_pass;
            r_exe_cmd       <= w_exe_cmd;
            r_rn            <= instr[19:16];
            r_rd            <= w_link_fin ? c_REG_LR : instr[15:12];
            r_shift_operand <= instr[11:0];
            r_simm24        <= instr[23:0];
            r_pc_out        <= pc_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_issued_cnt <= '0;
        end else if (w_issue && (r_issued_cnt != {CNT_W{1'b1}})) begin
            r_issued_cnt <= r_issued_cnt + 1'b1;
        end
    end

    assign out_valid     = r_out_valid;
    assign wb_en         = r_wb_en;
    assign mem_r_en      = r_mem_r_en;
    assign mem_w_en      = r_mem_w_en;
    assign b             = r_b;
    assign s             = r_s;
    assign imm           = r_imm;
    assign link          = r_link;
    assign illegal       = r_illegal;
    assign exe_cmd       = r_exe_cmd;
    assign rn            = r_rn;
    assign rd            = r_rd;
    assign shift_operand = r_shift_operand;
    assign simm24        = r_simm24;
    assign pc_out        = r_pc_out;
    assign issued_cnt    = r_issued_cnt;

endmodule
`default_nettype wire

// File: tb/tb_arm_id_decode_stage.sv
`default_nettype none
// Bench for arm_id_decode_stage: three instances (link on, link off, 2-bit
// counter) share one stimulus stream and are checked against a field model.
module tb_arm_id_decode_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, stall, flush, hazard;
    logic [31:0] instr, pc_in;
    logic [3:0]  nzcv;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // ---------------- instance outputs ----------------
    logic        m_ov, m_wb, m_mr, m_mw, m_b, m_s, m_imm, m_lk, m_ill;
    logic [3:0]  m_cmd, m_rn, m_rd;
    logic [11:0] m_sh;
    logic [23:0] m_si;
    logic [31:0] m_pc;
    logic [15:0] m_cnt;
    logic        n_ov, n_wb, n_mr, n_mw, n_b, n_s, n_imm, n_lk, n_ill;
    logic [3:0]  n_cmd, n_rn, n_rd;
    logic [11:0] n_sh;
    logic [23:0] n_si;
    logic [31:0] n_pc;
    logic [15:0] n_cnt;
    logic        c_ov, c_wb, c_mr, c_mw, c_b, c_s, c_imm, c_lk, c_ill;
    logic [3:0]  c_cmd, c_rn, c_rd;
    logic [11:0] c_sh;
    logic [23:0] c_si;
    logic [31:0] c_pc;
    logic [1:0]  c_cnt;

    arm_id_decode_stage #(.PC_W(32), .CNT_W(16), .EN_LINK(1'b1)) u_main (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .pc_in(pc_in),
        .nzcv(nzcv), .stall(stall), .flush(flush), .hazard(hazard),
        .out_valid(m_ov), .wb_en(m_wb), .mem_r_en(m_mr), .mem_w_en(m_mw), .b(m_b),
        .s(m_s), .imm(m_imm), .link(m_lk), .illegal(m_ill), .exe_cmd(m_cmd),
        .rn(m_rn), .rd(m_rd), .shift_operand(m_sh), .simm24(m_si), .pc_out(m_pc),
        .issued_cnt(m_cnt));

    arm_id_decode_stage #(.PC_W(32), .CNT_W(16), .EN_LINK(1'b0)) u_nolink (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .pc_in(pc_in),
        .nzcv(nzcv), .stall(stall), .flush(flush), .hazard(hazard),
        .out_valid(n_ov), .wb_en(n_wb), .mem_r_en(n_mr), .mem_w_en(n_mw), .b(n_b),
        .s(n_s), .imm(n_imm), .link(n_lk), .illegal(n_ill), .exe_cmd(n_cmd),
        .rn(n_rn), .rd(n_rd), .shift_operand(n_sh), .simm24(n_si), .pc_out(n_pc),
        .issued_cnt(n_cnt));

    arm_id_decode_stage #(.PC_W(32), .CNT_W(2), .EN_LINK(1'b1)) u_cnt2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .pc_in(pc_in),
        .nzcv(nzcv), .stall(stall), .flush(flush), .hazard(hazard),
        .out_valid(c_ov), .wb_en(c_wb), .mem_r_en(c_mr), .mem_w_en(c_mw), .b(c_b),
        .s(c_s), .imm(c_imm), .link(c_lk), .illegal(c_ill), .exe_cmd(c_cmd),
        .rn(c_rn), .rd(c_rd), .shift_operand(c_sh), .simm24(c_si), .pc_out(c_pc),
        .issued_cnt(c_cnt));

    wire [88:0] v_m = {m_ov, m_wb, m_mr, m_mw, m_b, m_s, m_imm, m_lk, m_ill,
                       m_cmd, m_rn, m_rd, m_sh, m_si, m_pc};
    wire [88:0] v_n = {n_ov, n_wb, n_mr, n_mw, n_b, n_s, n_imm, n_lk, n_ill,
                       n_cmd, n_rn, n_rd, n_sh, n_si, n_pc};
    wire [88:0] v_c = {c_ov, c_wb, c_mr, c_mw, c_b, c_s, c_imm, c_lk, c_ill,
                       c_cmd, c_rn, c_rd, c_sh, c_si, c_pc};

    // ---------------- reference model ----------------
    function automatic bit model_pass(input logic [31:0] ins, input logic [3:0] f);
        bit n, z, c, v;
        bit ct[16];
        {n, z, c, v} = f;
        ct = '{z, !z, c, !c, n, !n, v, !v, c && !z, !c || z, n == v, n != v,
               !z && (n == v), z || (n != v), 1'b1, 1'b0};
        return ct[ins[31:28]];
    endfunction

    // Data-processing opcode -> ALU command; -1 marks an undefined opcode.
    function automatic int alu_of(input logic [3:0] op);
        int tbl[16];
        tbl = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};
        return tbl[op];
    endfunction

    function automatic logic [88:0] model_dec(input logic [31:0] ins, input logic [31:0] pc,
                                              input logic [3:0] f, input logic v,
                                              input bit en_link);
        bit pass, wb, mr, mw, br, s, im, lk, ill;
        int cmd;
        logic [3:0] rd;
        if (!v) return '0;
        pass = model_pass(ins, f);
        {wb, mr, mw, br, s, im, lk, ill} = '0;
        cmd = 0;
        if (ins[27:26] == 2'b00 && alu_of(ins[24:21]) >= 0) begin
            cmd = alu_of(ins[24:21]);
            im  = ins[25];
            if (ins[24:21] == 4'hA || ins[24:21] == 4'h8) s = 1;
            else begin s = ins[20]; wb = 1; end
        end else if (ins[27:26] == 2'b01 && ins[24:21] == 4'h4) begin
            cmd = 2;
            if (ins[20]) begin mr = 1; wb = 1; end else mw = 1;
        end else if (ins[27:26] == 2'b10) begin
            br = 1;
            lk = en_link && ins[24];
            wb = lk;
        end else begin
            ill = 1;
        end
        if (!pass) {wb, mr, mw, br, s, lk, ill} = '0;
        rd = lk ? 4'd14 : ins[15:12];
        return {pass, wb, mr, mw, br, s, im, lk, ill, 4'(cmd), ins[19:16], rd,
                ins[11:0], ins[23:0], pc};
    endfunction

    logic [88:0] exp_m, exp_n;
    int          cnt_m, cnt_c;

    always @(posedge clk) begin
        if (rst) begin
            exp_m <= '0; exp_n <= '0; cnt_m <= 0; cnt_c <= 0;
        end else if (flush) begin
            exp_m <= '0; exp_n <= '0;
        end else if (!stall) begin
            if (hazard) begin
                exp_m <= '0; exp_n <= '0;
            end else begin
                exp_m <= model_dec(instr, pc_in, nzcv, in_valid, 1'b1);
                exp_n <= model_dec(instr, pc_in, nzcv, in_valid, 1'b0);
                if (in_valid && model_pass(instr, nzcv)) begin
                    cnt_m <= cnt_m + 1;
                    cnt_c <= (cnt_c == 3) ? 3 : cnt_c + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("main.fields",  v_m, exp_m);
            chk("nolink.fields", v_n, exp_n);
            chk("cnt2.fields",  v_c, exp_m);
            chk("main.cnt",     m_cnt, cnt_m);
            chk("nolink.cnt",   n_cnt, cnt_m);
            chk("cnt2.cnt",     c_cnt, cnt_c);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [31:0] ins, input logic [3:0] f, input logic v,
                        input logic st, input logic fl, input logic hz, input logic r);
        instr = ins; nzcv = f; in_valid = v; stall = st; flush = fl; hazard = hz; rst = r;
        pc_in = pc_in + 32'd4;
        @(posedge clk);
        #1;
    endtask

    typedef struct { logic [31:0] ins; logic [3:0] f; } vec_t;
    vec_t vecs[16];

    initial begin
        rst = 1; in_valid = 0; instr = 0; pc_in = 32'h1000; nzcv = 0;
        stall = 0; flush = 0; hazard = 0;
        step(32'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        step(32'hE2821005, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("reset.fields", v_m, 89'd0);
        chk("reset.cnt", m_cnt, 16'd0);

        step(32'hE2821005, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // ADD R1,R2,#5
        chk("add.ov", m_ov, 1'b1);
        chk("add.cmd", m_cmd, 4'b0010);
        chk("add.wb/imm", {m_wb, m_imm}, 2'b11);
        chk("add.rn/rd", {m_rn, m_rd}, 8'h21);
        chk("add.cnt", m_cnt, 16'd1);

        step(32'hE1520003, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // CMP R2,R3
        chk("cmp.s/wb", {m_s, m_wb}, 2'b10);
        chk("cmp.cmd", m_cmd, 4'b0100);
        step(32'hE4821000, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // STR R1,[R2], opcode field 0100
        chk("str.mw/wb/s", {m_mw, m_wb, m_s}, 3'b100);

        step(32'h02821005, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // ADDEQ, Z=0
        chk("addeq_fail.ov/wb", {m_ov, m_wb, m_mr, m_mw}, 4'b0000);
        step(32'h02821005, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // ADDEQ, Z=1
        chk("addeq_pass.ov/wb", {m_ov, m_wb}, 2'b11);
        chk("addeq.cnt", m_cnt, 16'd4);

        step(32'hEB000010, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // BL
        chk("bl.b/link/wb", {m_b, m_lk, m_wb}, 3'b111);
        chk("bl.rd", m_rd, 4'd14);
        chk("bl.simm24", m_si, 24'h000010);
        chk("bl_nolink.b/link/wb", {n_b, n_lk, n_wb}, 3'b100);

        step(32'hE4921000, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // LDR R1,[R2]
        chk("ldr.mr/wb", {m_mr, m_wb}, 2'b11);
        for (int i = 0; i < 3; i++) begin
            step(32'hE2821005, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            chk("stall.mr", {m_ov, m_mr}, 2'b11);
            chk("stall.cnt", m_cnt, 16'd6);
        end
        step(32'hE2821005, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("flush.bubble", v_m, 89'd0);
        chk("flush.cnt", m_cnt, 16'd6);
        step(32'hE2821005, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("hazard.bubble", v_m, 89'd0);
        step(32'hE2821005, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("invalid.bubble", m_ov, 1'b0);
        step(32'hF2821005, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // cond 1111
        chk("nv.ov", m_ov, 1'b0);

        vecs = '{
            '{32'hE3B03001, 4'h0}, '{32'hE1E04005, 4'h0}, '{32'hE0A21003, 4'h2},
            '{32'hE0C21003, 4'h1}, '{32'hE0021003, 4'h0}, '{32'hE1821003, 4'h8},
            '{32'hE0221003, 4'h0}, '{32'hE1120003, 4'h0}, '{32'hC0521003, 4'h0},
            '{32'hD0821005, 4'h8}, '{32'h82821005, 4'h2}, '{32'h92821005, 4'h2},
            '{32'hE0621003, 4'h0}, '{32'hE5821000, 4'h0}, '{32'hEA000005, 4'h0},
            '{32'hBB000003, 4'h9}};
        foreach (vecs[i]) step(vecs[i].ins, vecs[i].f, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        step(32'hE2821005, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(32'hE2821005, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);   // rst during stall
        chk("rst_stall.fields", v_m, 89'd0);
        chk("rst_stall.cnt", m_cnt, 16'd0);
        for (int i = 0; i < 5; i++) begin
            logic [1:0] want [5];
            want = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
            step(32'hE2821005, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("cnt2.sat", c_cnt, want[i]);
        end

        step(32'hEC000000, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // mode 11
        chk("undef.ill/ov", {m_ill, m_ov}, 2'b11);
        chk("undef.enables", {m_wb, m_mr, m_mw, m_b}, 4'b0000);
        step(32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
